// File: rtl/game_pkg.sv
// Shared game geometry, HP width and hit-tracker state encoding.
// Pure declarations: no latency and no backpressure.
package game_pkg;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int HP_W     = 4;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int N_SLOTS  = 5;

  typedef logic [X_W-1:0] coord_x_t;
  typedef logic [Y_W-1:0] coord_y_t;

  typedef enum logic [1:0] {IDLE, SCAN, HIT, DEAD} hit_state_t;
endpackage

// File: rtl/player_hit_tracker_if.sv
// Player/projectile geometry in, hit status out; master drives the geometry and the step strobe.
// Wiring only: no latency; no backpressure (step strobes are fire-and-forget).
interface player_hit_tracker_if;
  import game_pkg::*;

  logic             pulse_cycleStep;
  coord_x_t         playerX, playerW;
  coord_y_t         playerY, playerH;
  coord_x_t         proj1X, proj2X, proj3X, proj4X, proj5X, projW;
  coord_y_t         proj1Y, proj2Y, proj3Y, proj4Y, proj5Y, projH;
  logic             playerHit;
  logic [HP_W-1:0]  playerHP;
  logic             invuln;
  logic             playerDead;
`ifdef HIT_INDEX_EN
  logic [2:0]       hitIdx;
`endif

  modport master (
    output pulse_cycleStep, playerX, playerY, playerW, playerH,
    output proj1X, proj2X, proj3X, proj4X, proj5X, projW,
    output proj1Y, proj2Y, proj3Y, proj4Y, proj5Y, projH,
`ifdef HIT_INDEX_EN
    input  hitIdx,
`endif
    input  playerHit, playerHP, invuln, playerDead
  );

  modport slave (
    input  pulse_cycleStep, playerX, playerY, playerW, playerH,
    input  proj1X, proj2X, proj3X, proj4X, proj5X, projW,
    input  proj1Y, proj2Y, proj3Y, proj4Y, proj5Y, projH,
`ifdef HIT_INDEX_EN
    output hitIdx,
`endif
    output playerHit, playerHP, invuln, playerDead
  );
endinterface

// File: rtl/aabb_overlap.sv
// Strict axis-aligned box overlap; end coordinates widened by one bit so they never wrap.
// Combinational, zero latency; no backpressure.
module aabb_overlap
  import game_pkg::*;
(
  input  coord_x_t px,
  input  coord_x_t pw,
  input  coord_y_t py,
  input  coord_y_t ph,
  input  coord_x_t qx,
  input  coord_x_t qw,
  input  coord_y_t qy,
  input  coord_y_t qh,
  output logic     overlap
);
  logic [X_W:0] px_end, qx_end;
  logic [Y_W:0] py_end, qy_end;

  assign px_end = {1'b0, px} + {1'b0, pw};
  assign qx_end = {1'b0, qx} + {1'b0, qw};
  assign py_end = {1'b0, py} + {1'b0, ph};
  assign qy_end = {1'b0, qy} + {1'b0, qh};

  // Strict compares: boxes that only share an edge do not collide.
  assign overlap = ({1'b0, px} < qx_end) && ({1'b0, qx} < px_end) &&
                   ({1'b0, py} < qy_end) && ({1'b0, qy} < py_end);
endmodule

// File: rtl/player_hit_tracker.sv
// Per game step, snapshots geometry and scans 5 projectile slots one per clock; hit pulse 1-5 clocks after the step edge.
// No backpressure: steps arriving mid-scan only tick invulnerability. HIT_INDEX_EN adds the hitIdx output.
module player_hit_tracker
  import game_pkg::*;
#(
  parameter int MAX_HP       = 5,
  parameter int INVULN_STEPS = 8,
  parameter int SCREEN_H     = game_pkg::SCREEN_H
) (
  input  logic                 clk_master,
  input  logic                 rst,
  player_hit_tracker_if.slave  bus
);
  localparam int CW = (INVULN_STEPS < 1) ? 1 : $clog2(INVULN_STEPS + 1);
  localparam logic [Y_W:0] Y_LIMIT = (Y_W + 1)'(SCREEN_H);

  hit_state_t      state, state_d;
  logic [HP_W-1:0] hp, hp_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      idx, idx_d;
  logic            hit_q, hit_d, dead_q, dead_d, snap_en;

  coord_x_t snap_px, snap_pw, snap_qw;
  coord_y_t snap_py, snap_ph, snap_qh;
  coord_x_t snap_qx [N_SLOTS];
  coord_y_t snap_qy [N_SLOTS];
  coord_x_t cur_x;
  coord_y_t cur_y;
  logic     box_hit, overlap;

  always_comb begin
    cur_x = '0;
    cur_y = '0;
    case (idx)
      3'd0: begin cur_x = snap_qx[0]; cur_y = snap_qy[0]; end
      3'd1: begin cur_x = snap_qx[1]; cur_y = snap_qy[1]; end
      3'd2: begin cur_x = snap_qx[2]; cur_y = snap_qy[2]; end
      3'd3: begin cur_x = snap_qx[3]; cur_y = snap_qy[3]; end
      3'd4: begin cur_x = snap_qx[4]; cur_y = snap_qy[4]; end
      default: ;
    endcase
  end

  aabb_overlap u_aabb (
    .px(snap_px), .pw(snap_pw), .py(snap_py), .ph(snap_ph),
    .qx(cur_x),   .qw(snap_qw), .qy(cur_y),   .qh(snap_qh),
    .overlap(box_hit)
  );

  // Slots parked below the visible area are inactive.
  assign overlap = box_hit && ({1'b0, cur_y} < Y_LIMIT);

  always_comb begin
    state_d = state;
    hp_d    = hp;
    cnt_d   = cnt;
    idx_d   = idx;
    hit_d   = 1'b0;
    dead_d  = dead_q;
    snap_en = 1'b0;
    if (bus.pulse_cycleStep && (cnt != '0))
      cnt_d = cnt - CW'(1);
    case (state)
      IDLE: begin
        if (bus.pulse_cycleStep && (cnt == '0)) begin
          snap_en = 1'b1;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (overlap) begin
          hit_d   = 1'b1;
          hp_d    = hp - HP_W'(1);
          cnt_d   = CW'(INVULN_STEPS);
          dead_d  = (hp == HP_W'(1));
          state_d = HIT;
        end else if (idx == 3'd4) begin
          state_d = IDLE;
        end else begin
          idx_d = idx + 3'd1;
        end
      end
      HIT:  state_d = (hp == '0) ? DEAD : IDLE;
      DEAD: begin
        hp_d   = '0;
        dead_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_master or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge clk_master or negedge rst) begin
    if (!rst) begin
      hp      <= HP_W'(MAX_HP);
      cnt     <= '0;
      idx     <= '0;
      hit_q   <= 1'b0;
      dead_q  <= 1'b0;
      snap_px <= '0;
      snap_pw <= '0;
      snap_py <= '0;
      snap_ph <= '0;
      snap_qw <= '0;
      snap_qh <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        snap_qx[i] <= '0;
        snap_qy[i] <= '0;
      end
    end else begin
      hp     <= hp_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      hit_q  <= hit_d;
      dead_q <= dead_d;
      if (snap_en) begin
        snap_px    <= bus.playerX;
        snap_pw    <= bus.playerW;
        snap_py    <= bus.playerY;
        snap_ph    <= bus.playerH;
        snap_qw    <= bus.projW;
        snap_qh    <= bus.projH;
        snap_qx[0] <= bus.proj1X;
        snap_qx[1] <= bus.proj2X;
        snap_qx[2] <= bus.proj3X;
        snap_qx[3] <= bus.proj4X;
        snap_qx[4] <= bus.proj5X;
        snap_qy[0] <= bus.proj1Y;
        snap_qy[1] <= bus.proj2Y;
        snap_qy[2] <= bus.proj3Y;
        snap_qy[3] <= bus.proj4Y;
        snap_qy[4] <= bus.proj5Y;
      end
    end
  end

`ifdef HIT_INDEX_EN
  logic [2:0] hit_idx_q;
  always_ff @(posedge clk_master or negedge rst) begin
    if (!rst)       hit_idx_q <= '0;
    else if (hit_d) hit_idx_q <= idx + 3'd1;
  end
  assign bus.hitIdx = hit_idx_q;
`endif

  assign bus.playerHit  = hit_q;
  assign bus.playerHP   = hp;
  assign bus.invuln     = (cnt != '0);
  assign bus.playerDead = dead_q;
endmodule
